// File: rtl/quad_decoder_if.sv
// Encoder pins, control strobes and position/velocity results of quad_decoder.
// master = register/SPI side plus the encoder pins, slave = the decoder.
interface quad_decoder_if #(
  parameter int COUNT_WIDTH = 32,
  parameter int VEL_WIDTH   = 16
);
  logic                   quad_a;
  logic                   quad_b;
  logic                   index;
  logic                   index_clear_en;
  logic                   preset_load;
  logic [COUNT_WIDTH-1:0] preset_value;
  logic                   error_clear;
  logic [COUNT_WIDTH-1:0] count;
  logic                   direction;
  logic [VEL_WIDTH-1:0]   velocity;
  logic                   velocity_valid;
  logic                   error;

  modport master (
    output quad_a, quad_b, index, index_clear_en, preset_load, preset_value, error_clear,
    input  count, direction, velocity, velocity_valid, error
  );

  modport slave (
    input  quad_a, quad_b, index, index_clear_en, preset_load, preset_value, error_clear,
    output count, direction, velocity, velocity_valid, error
  );
endinterface

// File: rtl/quad_decoder.sv
// 4x quadrature decoder: synchronised and glitch-filtered A/B/index, wrapping
// position counter with preset/index zeroing, sticky error and windowed velocity.
module quad_decoder #(
  parameter int COUNT_WIDTH = 32,
  parameter int FILTER_LEN  = 3,
  parameter int VEL_PERIOD  = 16000,
  parameter int VEL_WIDTH   = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  quad_decoder_if.slave  bus
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int PCW = $clog2(VEL_PERIOD);
  localparam longint VMAX_L = (longint'(1) <<< (VEL_WIDTH - 1)) - 1;
  localparam longint VMIN_L = -(longint'(1) <<< (VEL_WIDTH - 1));
  localparam logic signed [COUNT_WIDTH:0] VMAX = (COUNT_WIDTH + 1)'(VMAX_L);
  localparam logic signed [COUNT_WIDTH:0] VMIN = (COUNT_WIDTH + 1)'(VMIN_L);

  // channel order: bit 0 = A, bit 1 = B, bit 2 = index
  logic [2:0] pin_w;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] filt_w;
  logic [2:0] prev_q;

  assign pin_w = {bus.index, bus.quad_b, bus.quad_a};

  always_ff @(posedge clk) begin
    sync1_q <= pin_w;
    sync2_q <= sync1_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filter
      logic [FCW-1:0] fcnt_q;
      logic           filt_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          fcnt_q <= '0;
          filt_q <= sync2_q[gi];
        end else if (sync2_q[gi] == filt_q) begin
          fcnt_q <= '0;
        end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
          filt_q <= sync2_q[gi];
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + FCW'(1);
        end
      end

      assign filt_w[gi] = filt_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) prev_q <= sync2_q;
    else          prev_q <= filt_w;
  end

  // Gray position along the forward cycle 00->10->11->01, as {B, A^B}
  logic [1:0] pos_new_w;
  logic [1:0] pos_old_w;
  logic [1:0] delta_w;
  logic       step_fwd_w;
  logic       step_rev_w;
  logic       illegal_w;
  logic       index_clr_w;
  logic       load_evt_w;

  assign pos_new_w   = {filt_w[1], filt_w[0] ^ filt_w[1]};
  assign pos_old_w   = {prev_q[1], prev_q[0] ^ prev_q[1]};
  assign delta_w     = pos_new_w - pos_old_w;
  assign step_fwd_w  = (delta_w == 2'd1);
  assign step_rev_w  = (delta_w == 2'd3);
  assign illegal_w   = (delta_w == 2'd2);
  assign index_clr_w = bus.index_clear_en & filt_w[2] & ~prev_q[2];
  assign load_evt_w  = bus.preset_load | index_clr_w;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   err_q, err_d;

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    err_d   = err_q;
    if (bus.preset_load)    count_d = bus.preset_value;
    else if (index_clr_w)   count_d = '0;
    else if (step_fwd_w)    count_d = count_q + COUNT_WIDTH'(1);
    else if (step_rev_w)    count_d = count_q - COUNT_WIDTH'(1);
    if (step_fwd_w)         dir_d = 1'b1;
    else if (step_rev_w)    dir_d = 1'b0;
    if (illegal_w)          err_d = 1'b1;
    else if (bus.error_clear) err_d = 1'b0;
  end

  logic [PCW-1:0]         per_q;
  logic                   per_last_w;
  logic [COUNT_WIDTH-1:0] snap_q;
  logic                   win_inv_q;
  logic                   win_bad_w;
  logic [VEL_WIDTH-1:0]   vel_q;
  logic [VEL_WIDTH-1:0]   vel_sat_w;
  logic                   vvalid_q;
  logic signed [COUNT_WIDTH:0] diff_w;

  assign per_last_w = (per_q == PCW'(VEL_PERIOD - 1));
  // a preset/index clear on the closing cycle itself also spoils the window
  assign win_bad_w  = win_inv_q | load_evt_w;
  assign diff_w     = $signed({count_d[COUNT_WIDTH-1], count_d})
                    - $signed({snap_q[COUNT_WIDTH-1], snap_q});

  always_comb begin
    vel_sat_w = diff_w[VEL_WIDTH-1:0];
    if (diff_w > VMAX)      vel_sat_w = VMAX[VEL_WIDTH-1:0];
    else if (diff_w < VMIN) vel_sat_w = VMIN[VEL_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q   <= '0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      per_q     <= '0;
      snap_q    <= '0;
      win_inv_q <= 1'b0;
      vel_q     <= '0;
      vvalid_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      vvalid_q <= 1'b0;
      if (per_last_w) begin
        per_q     <= '0;
        snap_q    <= count_d;
        win_inv_q <= 1'b0;
        if (!win_bad_w) begin
          vel_q    <= vel_sat_w;
          vvalid_q <= 1'b1;
        end
      end else begin
        per_q     <= per_q + PCW'(1);
        win_inv_q <= win_bad_w;
      end
    end
  end

  assign bus.count          = count_q;
  assign bus.direction      = dir_q;
  assign bus.error          = err_q;
  assign bus.velocity       = vel_q;
  assign bus.velocity_valid = vvalid_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with an integer-level reference model checked
// every cycle, plus hand-computed expectations at the end of each scenario.
module tb_quad_decoder;
  localparam int CW  = 8;
  localparam int FL  = 3;
  localparam int VP  = 100;
  localparam int VW  = 4;
  localparam int CMASK = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n;

  quad_decoder_if #(.COUNT_WIDTH(CW), .VEL_WIDTH(VW)) bus_if ();

  quad_decoder #(
    .COUNT_WIDTH(CW), .FILTER_LEN(FL), .VEL_PERIOD(VP), .VEL_WIDTH(VW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_s1[3], m_s2[3], m_filt[3], m_prev[3], m_run[3];
  int m_count, m_dir, m_err, m_vel, m_vvalid, m_snap, m_inv, m_edges;

  function automatic int phase_of(input int a, input int b);
    if (a == 0 && b == 0) return 0;
    if (a == 1 && b == 0) return 1;
    if (a == 1 && b == 1) return 2;
    return 3;
  endfunction

  function automatic int as_signed(input int v);
    return (v >= (1 << (CW - 1))) ? v - (1 << CW) : v;
  endfunction

  task automatic model_edge();
    int pins[3];
    int d, nxt, rise, evt, diff;
    pins[0] = int'(bus_if.quad_a);
    pins[1] = int'(bus_if.quad_b);
    pins[2] = int'(bus_if.index);
    if (!reset_n) begin
      m_count = 0; m_dir = 0; m_err = 0; m_vel = 0; m_vvalid = 0;
      m_snap = 0; m_inv = 0; m_edges = 0;
      for (int c = 0; c < 3; c++) begin
        m_filt[c] = m_s2[c]; m_prev[c] = m_s2[c]; m_run[c] = 0;
      end
    end else begin
      d    = (phase_of(m_filt[0], m_filt[1]) - phase_of(m_prev[0], m_prev[1]) + 4) % 4;
      rise = (m_filt[2] == 1 && m_prev[2] == 0) ? 1 : 0;
      evt  = 0;
      nxt  = m_count;
      if (bus_if.preset_load) begin
        nxt = int'(bus_if.preset_value); evt = 1;
      end else if (bus_if.index_clear_en && rise == 1) begin
        nxt = 0; evt = 1;
      end else if (d == 1) nxt = m_count + 1;
      else if (d == 3) nxt = m_count - 1;
      nxt = nxt & CMASK;
      if (d == 1) m_dir = 1;
      if (d == 3) m_dir = 0;
      if (d == 2) m_err = 1;
      else if (bus_if.error_clear) m_err = 0;
      m_vvalid = 0;
      if (m_edges % VP == VP - 1) begin
        if (m_inv == 0 && evt == 0) begin
          diff = as_signed(nxt) - as_signed(m_snap);
          if (diff > (1 << (VW - 1)) - 1) diff = (1 << (VW - 1)) - 1;
          if (diff < -(1 << (VW - 1)))    diff = -(1 << (VW - 1));
          m_vel = diff; m_vvalid = 1;
        end
        m_snap = nxt; m_inv = 0;
      end else if (evt == 1) m_inv = 1;
      m_edges++;
      m_count = nxt;
      for (int c = 0; c < 3; c++) begin
        m_prev[c] = m_filt[c];
        if (m_s2[c] == m_filt[c]) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == FL) begin m_filt[c] = m_s2[c]; m_run[c] = 0; end
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      m_s2[c] = m_s1[c];
      m_s1[c] = pins[c];
    end
  endtask

  // compare process: model advances at posedge, DUT sampled at negedge
  initial begin
    m_s1[0] = 1; m_s1[1] = 1; m_s1[2] = 0;
    m_s2 = m_s1;
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      chk("count",          int'(bus_if.count), m_count);
      chk("direction",      int'(bus_if.direction), m_dir);
      chk("error",          int'(bus_if.error), m_err);
      chk("velocity",       int'($signed(bus_if.velocity)), m_vel);
      chk("velocity_valid", int'(bus_if.velocity_valid), m_vvalid);
    end
  end

  // ---------------- stimulus ----------------
  int ph = 2;
  logic [1:0] ab_tab [4];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input int dir, input int hold);
    logic [1:0] ab;
    ph = (ph + dir + 4) % 4;
    ab = ab_tab[ph];
    bus_if.quad_a = ab[1];
    bus_if.quad_b = ab[0];
    tick(hold);
  endtask

  task automatic preset(input int v);
    bus_if.preset_value = CW'(v);
    bus_if.preset_load  = 1'b1;
    tick(1);
    bus_if.preset_load  = 1'b0;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    logic [CW-1:0] c0;
    ab_tab[0] = 2'b00; ab_tab[1] = 2'b10; ab_tab[2] = 2'b11; ab_tab[3] = 2'b01;
    reset_n = 1'b0;
    bus_if.quad_a = 1'b1; bus_if.quad_b = 1'b1; bus_if.index = 1'b0;
    bus_if.index_clear_en = 1'b0; bus_if.preset_load = 1'b0;
    bus_if.preset_value = '0; bus_if.error_clear = 1'b0;
    tick(4);
    chk("reset_count", int'(bus_if.count), 0);
    chk("reset_valid", int'(bus_if.velocity_valid), 0);
    reset_n = 1'b1;
    tick(5);

    // 1: forward x8 with latency measurement on the first step, then reverse x8
    c0 = bus_if.count;
    ph = 3; bus_if.quad_a = 1'b0;
    n = 0;
    while (bus_if.count == c0 && n < 20) begin tick(1); n++; end
    chk("first_step_latency", n, 3 + FL);
    tick(10 - n);
    for (int i = 0; i < 7; i++) step(1, 10);
    chk("fwd8_count", int'(bus_if.count), 8);
    chk("fwd8_dir", int'(bus_if.direction), 1);
    chk("fwd8_err", int'(bus_if.error), 0);
    for (int i = 0; i < 8; i++) step(-1, 10);
    chk("rev8_count", int'(bus_if.count), 0);
    chk("rev8_dir", int'(bus_if.direction), 0);

    // 2: 2-cycle glitch rejected, 3-cycle pulse accepted (step and step back)
    bus_if.quad_a = 1'b0; tick(2); bus_if.quad_a = 1'b1; tick(12);
    chk("glitch_count", int'(bus_if.count), 0);
    chk("glitch_err", int'(bus_if.error), 0);
    chk("glitch_dir", int'(bus_if.direction), 0);
    bus_if.quad_a = 1'b0; tick(3); bus_if.quad_a = 1'b1; tick(12);
    chk("pulse3_count", int'(bus_if.count), 0);
    chk("pulse3_dir", int'(bus_if.direction), 0);

    // 3: illegal 11->00, then 00->11 with coincident error_clear, then lone clear
    bus_if.quad_a = 1'b0; bus_if.quad_b = 1'b0; ph = 0; tick(10);
    chk("illegal_err", int'(bus_if.error), 1);
    chk("illegal_count", int'(bus_if.count), 0);
    chk("illegal_dir", int'(bus_if.direction), 0);
    bus_if.quad_a = 1'b1; bus_if.quad_b = 1'b1; ph = 2;
    tick(3 + FL - 1);
    bus_if.error_clear = 1'b1; tick(1); bus_if.error_clear = 1'b0;
    tick(4);
    chk("set_and_clear_err", int'(bus_if.error), 1);
    bus_if.error_clear = 1'b1; tick(1); bus_if.error_clear = 1'b0; tick(2);
    chk("lone_clear_err", int'(bus_if.error), 0);

    // 4: wrap at the signed boundary and below zero
    preset(8'h7F);
    chk("preset_7f", int'(bus_if.count), 8'h7F);
    step(1, 10);
    chk("wrap_up", int'(bus_if.count), 8'h80);
    preset(0);
    step(-1, 10);
    chk("wrap_down", int'(bus_if.count), 8'hFF);
    chk("wrap_down_dir", int'(bus_if.direction), 0);

    // 5: index zeroing, simultaneous step dropped, disabled index ignored
    preset(37);
    bus_if.index_clear_en = 1'b1;
    bus_if.index = 1'b1;
    step(1, 10);
    chk("index_step_count", int'(bus_if.count), 0);
    chk("index_step_dir", int'(bus_if.direction), 1);
    bus_if.index = 1'b0; tick(10);
    preset(37);
    bus_if.index = 1'b1; tick(10); bus_if.index = 1'b0; tick(10);
    chk("index_clear", int'(bus_if.count), 0);
    bus_if.index_clear_en = 1'b0;
    preset(37);
    bus_if.index = 1'b1; tick(10); bus_if.index = 1'b0; tick(10);
    chk("index_disabled", int'(bus_if.count), 37);

    // 6: velocity windows aligned to a fresh reset release
    reset_n = 1'b0; tick(4); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 10);
    tick(VP - 50);
    chk("vel5_valid", int'(bus_if.velocity_valid), 1);
    chk("vel5_value", int'($signed(bus_if.velocity)), 5);
    tick(1);
    chk("vel5_pulse_len", int'(bus_if.velocity_valid), 0);
    for (int i = 0; i < 20; i++) step(1, 4);
    tick(VP - 81);
    chk("vel_sat_valid", int'(bus_if.velocity_valid), 1);
    chk("vel_sat_value", int'($signed(bus_if.velocity)), 7);
    tick(10);
    preset(8'h40);
    tick(VP - 13);
    chk("vel_preset_valid", int'(bus_if.velocity_valid), 0);
    chk("vel_preset_held", int'($signed(bus_if.velocity)), 7);
    step(1, 10); step(1, 10);
    reset_n = 1'b0; tick(3);
    chk("midreset_vel", int'($signed(bus_if.velocity)), 0);
    chk("midreset_valid", int'(bus_if.velocity_valid), 0);
    chk("midreset_count", int'(bus_if.count), 0);
    reset_n = 1'b1;
    tick(VP + 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Parametrised 4x quadrature encoder decoder, the next generation of the motorboard's position counter.
- Adds over the existing 8-bit counter: input synchronisation, glitch filtering, configurable counter width, index-pulse zeroing, preset load, illegal-transition detection and a periodic velocity measurement.
- Sits between the motor encoder pins and the register/SPI interface on the TinyFPGA-BX.

Parameters:
COUNT_WIDTH, 32, position counter width (two's complement, >=8)
FILTER_LEN, 3, consecutive stable cycles required before a filtered input changes (>=1)
VEL_PERIOD, 16000, velocity window length in clk cycles (1 ms at 16 MHz, >=2)
VEL_WIDTH, 16, velocity output width (signed, saturating, <=COUNT_WIDTH)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
quad_a  in  1  encoder channel A, asynchronous
quad_b  in  1  encoder channel B, asynchronous
index  in  1  encoder index pulse, asynchronous
index_clear_en  in  1  when 1, rising edge of filtered index zeroes count
preset_load  in  1  single-cycle strobe: load preset_value into count
preset_value  in  COUNT_WIDTH  value loaded by preset_load
error_clear  in  1  single-cycle strobe: clear sticky error
count  out  COUNT_WIDTH  signed position, counts per edge (4x)
direction  out  1  direction of last valid step, 1 = forward
velocity  out  VEL_WIDTH  signed count delta over last valid window
velocity_valid  out  1  one-cycle pulse when velocity updates
error  out  1  sticky illegal-transition flag

Behaviour:
- Reset: one clock; synchronous, active-low. While reset_n=0:
  - count=0, direction=0, velocity=0, velocity_valid=0, error=0.
  - Period counter=0, snapshot=0, window_invalid=0.
  - Filter stability counters=0.
- Synchronisers and reset seeding:
  - 2-flop synchroniser per input (A, B, index). These flops are not reset.
  - During reset, filtered A/B/index and previous-state registers load the synchroniser outputs every cycle, so no step or index edge is seen on reset release.
  - reset_n must be held >=3 cycles.
- Filter, per input:
  - Counter increments while sync != filtered. It clears when they are equal.
  - When the counter reaches FILTER_LEN, filtered <= sync and the counter clears.
  - Pulses shorter than FILTER_LEN cycles are discarded.
  - Latency from the first clk edge sampling a new pin level to the updated count: exactly 3+FILTER_LEN edges.
- Decode: state {A,B} filtered vs previous filtered, evaluated every cycle.
  - Forward, +1: 00->10->11->01->00.
  - Reverse, -1: 00->01->11->10->00.
  - No change: nothing.
  - Both bits changed: illegal. Count unchanged, direction unchanged, error<=1.
- Count update priority, one action per cycle:
  1. preset_load: count<=preset_value.
  2. index_clear_en && filtered-index rising edge: count<=0.
  3. Valid step: count +/-1, wrapping modulo 2^COUNT_WIDTH (0x7FFF..F +1 -> 0x800..0; 0 -1 -> all ones).
  - A step coinciding with 1 or 2 is dropped, but direction still updates.
- Error:
  - Set by an illegal transition; cleared by error_clear.
  - Simultaneous set and clear: error=1.
- Velocity:
  - Period counter runs 0..VEL_PERIOD-1 and wraps.
  - Any preset load or index clear during a window sets window_invalid.
  - On the cycle the period counter = VEL_PERIOD-1:
    - If !window_invalid: velocity <= sat(count_next - snapshot); velocity_valid=1 next cycle for exactly 1 cycle.
    - If window_invalid: velocity holds, no pulse.
    - Always: snapshot <= count_next, window_invalid <= 0.
  - count_next is the value count takes at that edge.
  - Difference is computed in COUNT_WIDTH+1 bits, then saturated to [-2^(VEL_WIDTH-1), 2^(VEL_WIDTH-1)-1].
- Reset mid-operation: all state returns to reset values next edge; no pulse is emitted.

Test Plan:
1. FILTER_LEN=3: release reset with A=B=1. Apply 8 forward quadrature steps, each level held 10 cycles. -> count=8, direction=1, error=0. First count change exactly 6 edges after first sampled edge. Repeat in reverse -> count=0, direction=0.
2. 2-cycle glitch on A -> count, error unchanged. 3-cycle pulse -> filter accepts it (one step, then one step back).
3. Force AB 00->11 -> error=1, count unchanged. Then error_clear together with a second illegal change -> error stays 1. Lone error_clear -> 0.
4. COUNT_WIDTH=8, preset_value=0x7F, preset_load, one forward step -> count=0x80. Preset 0x00, one reverse step -> 0xFF.
5. index_clear_en=1 with count=37, then index pulse -> count=0 on the edge after the filtered rising edge. A simultaneous step is dropped. index_clear_en=0 -> count unaffected.
6. VEL_PERIOD=100, VEL_WIDTH=4, 5 forward steps in a window -> velocity=5 with one-cycle pulse. 20 steps -> velocity=7 (saturated). Window containing a preset -> no pulse, velocity held. reset_n low mid-window -> velocity=0, no pulse.
